mult_12_sched: RTL and testbench

- Shares one pipelined 12-bit float multiplier (1 sign, 5 exp bias 15, 6 mantissa; fixed latency, no stall) among NUM_REQ requesters.
- Arbitrates operand pairs round-robin and drives the multiplier inputs.
- Tracks each issued operation through a tag pipeline and returns each product with the requester's ID.
- Sits between the neuron processing lanes and the single mult_12 instance.

---
 rtl/mult_12_sched.sv | 91 +++++++++
 tb/tb_mult_12_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_12_sched.sv
// mult_12_sched: round-robin scheduler that shares one pipelined 12-bit float multiplier among requesters
// and returns each product tagged with the requester index.
module mult_12_sched #(
    parameter int NUM_REQ  = 4,
    parameter int MULT_LAT = 3,
    parameter int MAX_OUT  = 4,
    parameter int ID_W     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  logic [NUM_REQ*12-1:0] req_data_1_i,
    input  logic [NUM_REQ*12-1:0] req_data_2_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    output logic [11:0]           mult_data_1_o,
    output logic [11:0]           mult_data_2_o,
    input  logic [11:0]           mult_data_i,
    output logic                  res_valid_o,
    output logic [ID_W-1:0]       res_id_o,
    output logic [11:0]           res_data_o,
    output logic                  idle_o
);
    localparam int CW = $clog2(MAX_OUT + 1);

    logic [ID_W-1:0]             ptr;
    logic [ID_W-1:0]             win;
    logic                        hit;
    logic [NUM_REQ-1:0]          elig;
    logic [NUM_REQ-1:0]          done;
    logic [NUM_REQ-1:0][CW-1:0]  cnt;
    logic [MULT_LAT:0]           tag_v;
    logic [MULT_LAT:0][ID_W-1:0] tag_id;

    always_comb begin
        elig = '0;
        done = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid_i[i] && enable_i && (cnt[i] < CW'(MAX_OUT));
            done[i] = tag_v[MULT_LAT] && (tag_id[MULT_LAT] == ID_W'(i));
        end
    end

    // Scan from farthest to nearest so the eligible requester closest after ptr wins.
    always_comb begin
        win = ptr;
        hit = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (elig[ID_W'((int'(ptr) + k) % NUM_REQ)]) begin
                win = ID_W'((int'(ptr) + k) % NUM_REQ);
                hit = 1'b1;
            end
        end
    end

    assign req_ready_o = hit ? (NUM_REQ'(1) << win) : '0;
    assign idle_o      = ~|tag_v && !res_valid_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr           <= ID_W'(NUM_REQ - 1);
            mult_data_1_o <= '0;
            mult_data_2_o <= '0;
            tag_v         <= '0;
            tag_id        <= '0;
            res_valid_o   <= 1'b0;
            res_id_o      <= '0;
            res_data_o    <= '0;
            cnt           <= '0;
        end else begin
            tag_v       <= {tag_v[MULT_LAT-1:0], hit};
            tag_id      <= {tag_id[MULT_LAT-1:0], win};
            res_valid_o <= tag_v[MULT_LAT];
            if (hit) begin
                ptr           <= win;
                mult_data_1_o <= req_data_1_i[win*12 +: 12];
                mult_data_2_o <= req_data_2_i[win*12 +: 12];
            end
            if (tag_v[MULT_LAT]) begin
                res_data_o <= mult_data_i;
                res_id_o   <= tag_id[MULT_LAT];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready_o[i] && !done[i])
                    cnt[i] <= cnt[i] + CW'(1);
                else if (done[i] && !req_ready_o[i])
                    cnt[i] <= cnt[i] - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mult_12_sched.sv
// tb_mult_12_sched: vector table, directed sequences and randomized traffic against a
// queue-based scheduling model, with a behavioural float multiplier pipeline feeding the DUT.
module tb_mult_12_sched;
    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int MO  = 4;
    localparam int IW  = 2;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic            enable_i = 1'b0;
    logic [N-1:0]    req_valid_i = '0;
    logic [N*12-1:0] req_data_1_i = '0;
    logic [N*12-1:0] req_data_2_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [11:0]     mult_data_1_o;
    logic [11:0]     mult_data_2_o;
    logic [11:0]     mult_data_i;
    logic            res_valid_o;
    logic [IW-1:0]   res_id_o;
    logic [11:0]     res_data_o;
    logic            idle_o;
    logic [11:0]     mpipe [LAT];

    mult_12_sched #(.NUM_REQ(N), .MULT_LAT(LAT), .MAX_OUT(MO), .ID_W(IW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
        .req_valid_i(req_valid_i), .req_data_1_i(req_data_1_i), .req_data_2_i(req_data_2_i),
        .req_ready_o(req_ready_o), .mult_data_1_o(mult_data_1_o), .mult_data_2_o(mult_data_2_o),
        .mult_data_i(mult_data_i), .res_valid_o(res_valid_o), .res_id_o(res_id_o),
        .res_data_o(res_data_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    // Normal-only truncating float multiply: enough to give each product a distinct value.
    function automatic logic [11:0] fmul(logic [11:0] a, logic [11:0] b);
        logic [13:0] p;
        logic [6:0]  e;
        logic [5:0]  m;
        p = {1'b1, a[5:0]} * {1'b1, b[5:0]};
        e = 7'(a[10:6]) + 7'(b[10:6]) - 7'd15;
        if (p[13]) begin
            m = p[12:7];
            e = e + 7'd1;
        end else m = p[11:6];
        return {a[11] ^ b[11], e[4:0], m};
    endfunction

    always @(posedge clk_i) begin
        mpipe[0] <= fmul(mult_data_1_o, mult_data_2_o);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mult_data_i = mpipe[LAT-1];

    typedef struct {
        int            due;
        logic [IW-1:0] id;
        logic [11:0]   data;
    } ent_t;

    typedef struct {
        logic          rst;
        logic [N-1:0]  valid;
        logic          en;
        logic [N-1:0]  ready;
        logic          rv;
        logic [IW-1:0] rid;
    } vec_t;

    ent_t          q[$];
    vec_t          vt[16];
    int            cyc, ptr, total, bad;
    logic [11:0]   exp_m1, exp_m2, last_data;
    logic [IW-1:0] last_id;
    logic [N-1:0]  s_ready, mask;
    logic          s_rv;
    logic [IW-1:0] s_rid;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        cyc       = 0;
        ptr       = N - 1;
        exp_m1    = '0;
        exp_m2    = '0;
        last_data = '0;
        last_id   = '0;
    endfunction

    task automatic rand_data();
        req_data_1_i = 48'({$urandom(), $urandom()});
        req_data_2_i = 48'({$urandom(), $urandom()});
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_mult_a", mult_data_1_o, 0);
        chk("rst_mult_b", mult_data_2_o, 0);
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_res_id", res_id_o, 0);
        chk("rst_res_data", res_data_o, 0);
        chk("rst_idle", idle_o, 1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    // One clock cycle: predict, sample at negedge, compare, then advance the model.
    task automatic step();
        int   outs[N];
        int   win;
        logic [N-1:0] er;
        logic ev;
        foreach (outs[i]) outs[i] = 0;
        foreach (q[j]) if (q[j].due > cyc) outs[q[j].id]++;
        win = -1;
        for (int k = 1; k <= N; k++) begin
            int r;
            r = (ptr + k) % N;
            if (req_valid_i[r] && enable_i && outs[r] < MO) begin
                win = r;
                break;
            end
        end
        er = (win < 0) ? '0 : (N'(1) << win);
        ev = q.size() > 0 && q[0].due == cyc;
        @(negedge clk_i);
        s_ready = req_ready_o;
        s_rv    = res_valid_o;
        s_rid   = res_id_o;
        chk("ready", req_ready_o, er);
        chk("mult_a", mult_data_1_o, exp_m1);
        chk("mult_b", mult_data_2_o, exp_m2);
        chk("res_valid", res_valid_o, ev);
        chk("idle", idle_o, q.size() == 0);
        if (ev) begin
            last_id   = q[0].id;
            last_data = q[0].data;
            void'(q.pop_front());
        end
        chk("res_id", res_id_o, last_id);
        chk("res_data", res_data_o, last_data);
        if (win >= 0) begin
            exp_m1 = req_data_1_i[win*12 +: 12];
            exp_m2 = req_data_2_i[win*12 +: 12];
            q.push_back('{cyc + LAT + 2, IW'(win), fmul(exp_m1, exp_m2)});
            ptr = win;
        end
        cyc++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(int n);
        req_valid_i = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        // Contention from reset (rows 0-7), then credit limit on requester 2 (rows 8-15).
        vt[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
        vt[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0};
        vt[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b0, 2'd0};
        vt[3]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b0, 2'd0};
        vt[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
        vt[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
        vt[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
        vt[7]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
        vt[8]  = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0};
        vt[9]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0};
        vt[10] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0};
        vt[11] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0};
        vt[12] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0};
        vt[13] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        vt[14] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        vt[15] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (vt[i].rst) do_reset();
            req_valid_i = vt[i].valid;
            enable_i    = vt[i].en;
            rand_data();
            step();
            chk("tbl_ready", s_ready, vt[i].ready);
            chk("tbl_res_valid", s_rv, vt[i].rv);
            chk("tbl_res_id", s_rid, vt[i].rid);
        end
        drain(8);

        // Single op: 1.0 * 2.0 from requester 0.
        do_reset();
        enable_i     = 1'b1;
        req_valid_i  = 4'b0001;
        req_data_1_i = '0;
        req_data_2_i = '0;
        req_data_1_i[11:0] = 12'h3C0;
        req_data_2_i[11:0] = 12'h400;
        step();
        chk("single_mult_a", mult_data_1_o, 12'h3C0);
        req_valid_i = '0;
        for (int i = 0; i < 4; i++) step();
        chk("single_res_valid", res_valid_o, 1);
        chk("single_res_id", res_id_o, 0);
        chk("single_res_data", res_data_o, 12'h400);
        step();
        chk("single_idle", idle_o, 1);

        // Enable gating with three operations in flight.
        do_reset();
        enable_i    = 1'b1;
        req_valid_i = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step();
        end
        enable_i = 1'b0;
        step();
        chk("gate_ready", s_ready, 0);
        for (int i = 0; i < 8; i++) step();
        chk("gate_idle", idle_o, 1);
        enable_i = 1'b1;
        step();
        chk("gate_resume", s_ready, 4'b1000);
        drain(8);

        // Reset while two operations are in flight.
        do_reset();
        enable_i     = 1'b1;
        req_valid_i  = 4'b1111;
        req_data_1_i = {4{12'h3C0}};
        req_data_2_i = {4{12'h400}};
        step();
        step();
        rst_i = 1'b1;
        #2;
        chk("midrst_mult_a", mult_data_1_o, 0);
        chk("midrst_idle", idle_o, 1);
        chk("midrst_res_valid", res_valid_o, 0);
        do_reset();
        drain(10);
        req_valid_i = 4'b1111;
        step();
        chk("midrst_first_grant", s_ready, 4'b0001);
        drain(8);

        // Mixed: requesters 1 and 3, then 3 drops.
        do_reset();
        enable_i    = 1'b1;
        req_valid_i = 4'b1010;
        rand_data();
        step();
        chk("mixed_g0", s_ready, 4'b0010);
        step();
        chk("mixed_g1", s_ready, 4'b1000);
        req_valid_i = 4'b0010;
        step();
        chk("mixed_g2", s_ready, 4'b0010);
        step();
        chk("mixed_g3", s_ready, 4'b0010);
        drain(8);

        // Randomized traffic; held masks drive single requesters into the credit limit.
        do_reset();
        mask = '0;
        for (int c = 0; c < 600; c++) begin
            if (c % 16 == 0) mask = N'($urandom_range(15));
            req_valid_i = ($urandom_range(3) == 0) ? N'($urandom()) : mask;
            enable_i    = $urandom_range(7) != 0;
            rand_data();
            step();
        end
        drain(8);
        chk("final_idle", idle_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
